// File: rtl/crystal_scan_scheduler.sv
// ---------------------------------------------------------------------------
// crystal_scan_scheduler
//
// Sequences the crystal_read scanner. The block raises get_crystal_array for
// PULSE_LEN cycles, drops it for one cycle and then waits SCAN_WAIT cycles.
// After that it checks that the eight 4-bit crystal mappings on map_in form a
// legal permutation of 0..7. A scan that fails the check is retried, up to
// MAX_RETRY attempts per request. The last validated map is published on
// map_out.
//
// A scan is started by on-demand requests from two clients (round-robin when
// both ask) or by a periodic auto-rescan timer.
//
// Ports
//   system_clk         clock
//   rst                synchronous active-high reset
//   auto_en            enable periodic rescans
//   req_a / req_b      level scan requests from clients A and B
//   gnt_a / gnt_b      1-cycle pulse when the matching request is accepted
//   get_crystal_array  trigger to crystal_read
//   map_in             crystal_read outputs, crystal A at [3:0] .. 8 at [31:28]
//   map_out            last validated map
//   map_valid          map_out came from a validated scan
//   scan_busy          scheduler is not idle
//   scan_done          1-cycle pulse at the end of every request
//   scan_error         last request exhausted its retries
//   retry_cnt          failed attempts in the current/last request
// ---------------------------------------------------------------------------
module crystal_scan_scheduler #(
    parameter logic [7:0]  PULSE_LEN   = 8'd4,
    parameter logic [19:0] SCAN_WAIT   = 20'd450000,
    parameter logic [23:0] PERIOD      = 24'd5000000,
    parameter logic [1:0]  MAX_RETRY   = 2'd3,
    parameter logic [31:0] DEFAULT_MAP = 32'h65432107
) (
    input  logic        system_clk,
    input  logic        rst,
    input  logic        auto_en,
    input  logic        req_a,
    input  logic        req_b,
    output logic        gnt_a,
    output logic        gnt_b,
    output logic        get_crystal_array,
    input  logic [31:0] map_in,
    output logic [31:0] map_out,
    output logic        map_valid,
    output logic        scan_busy,
    output logic        scan_done,
    output logic        scan_error,
    output logic [1:0]  retry_cnt
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PULSE_HI = 3'd1,
        S_PULSE_LO = 3'd2,
        S_WAIT     = 3'd3,
        S_CHECK    = 3'd4
    } state_t;

    // The map is legal when every field is below 8 and the fields together
    // cover all eight crystal positions.
    function automatic logic map_is_perm(input logic [31:0] m);
        logic [7:0] seen;
        logic       in_range;
        seen     = 8'h00;
        in_range = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_range = in_range & ~m[4*i+3];
            seen     = seen | (8'h01 << m[4*i +: 3]);
        end
        return in_range & (seen == 8'hFF);
    endfunction

    // One counter serves both the pulse-high phase and the scan wait.
    // The two phases never overlap, so the counter can be shared.
    localparam logic [19:0] PULSE_LAST = {12'd0, PULSE_LEN} - 20'd1;
    localparam logic [19:0] WAIT_LAST  = SCAN_WAIT - 20'd1;
    localparam logic [23:0] PERIOD_LAST = PERIOD - 24'd1;

    state_t       state_q,      state_d;
    logic [19:0]  cnt_q,        cnt_d;
    logic [23:0]  period_q,     period_d;
    logic         rr_b_q,       rr_b_d;      // 1: client B has priority
    logic [1:0]   retry_q,      retry_d;
    logic [31:0]  map_out_q,    map_out_d;
    logic         map_valid_q,  map_valid_d;
    logic         scan_error_q, scan_error_d;
    logic         scan_done_q,  scan_done_d;
    logic         gnt_a_q,      gnt_a_d;
    logic         gnt_b_q,      gnt_b_d;
    logic         trig_q,       trig_d;
    logic         busy_q,       busy_d;

    logic         pick_a_s;
    logic         pick_b_s;
    logic         auto_fire_s;

    // Arbitration between the two clients and the auto-rescan timer.
    always_comb begin
        pick_a_s    = 1'b0;
        pick_b_s    = 1'b0;
        auto_fire_s = 1'b0;
        if (req_a && req_b) begin
            if (rr_b_q) begin
                pick_b_s = 1'b1;
            end else begin
                pick_a_s = 1'b1;
            end
        end else if (req_a) begin
            pick_a_s = 1'b1;
        end else if (req_b) begin
            pick_b_s = 1'b1;
        end else if (auto_en && (period_q == PERIOD_LAST)) begin
            auto_fire_s = 1'b1;
        end else begin
            auto_fire_s = 1'b0;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        period_d     = period_q;
        rr_b_d       = rr_b_q;
        retry_d      = retry_q;
        map_out_d    = map_out_q;
        map_valid_d  = map_valid_q;
        scan_error_d = scan_error_q;
        scan_done_d  = 1'b0;
        gnt_a_d      = 1'b0;
        gnt_b_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pick_a_s || pick_b_s || auto_fire_s) begin
                    state_d  = S_PULSE_HI;
                    cnt_d    = 20'd0;
                    period_d = 24'd0;
                    retry_d  = 2'd0;
                    gnt_a_d  = pick_a_s;
                    gnt_b_d  = pick_b_s;
                    if (pick_a_s) begin
                        rr_b_d = 1'b1;
                    end else if (pick_b_s) begin
                        rr_b_d = 1'b0;
                    end else begin
                        rr_b_d = rr_b_q;
                    end
                end else if (auto_en) begin
                    period_d = period_q + 24'd1;
                end else begin
                    period_d = 24'd0;
                end
            end
            S_PULSE_HI: begin
                if (cnt_q == PULSE_LAST) begin
                    state_d = S_PULSE_LO;
                    cnt_d   = 20'd0;
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end
            S_PULSE_LO: begin
                cnt_d   = 20'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = S_CHECK;
                    cnt_d   = 20'd0;
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end
            S_CHECK: begin
                if (map_is_perm(map_in)) begin
                    map_out_d    = map_in;
                    map_valid_d  = 1'b1;
                    scan_error_d = 1'b0;
                    scan_done_d  = 1'b1;
                    state_d      = S_IDLE;
                end else if (({1'b0, retry_q} + 3'd1) < {1'b0, MAX_RETRY}) begin
                    retry_d = retry_q + 2'd1;
                    cnt_d   = 20'd0;
                    state_d = S_PULSE_HI;
                end else begin
                    if (retry_q == 2'd3) begin
                        retry_d = 2'd3;
                    end else begin
                        retry_d = retry_q + 2'd1;
                    end
                    scan_error_d = 1'b1;
                    scan_done_d  = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 20'd0;
            end
        endcase

        // Trigger and busy are derived from the next state so they line up
        // with the registered state.
        trig_d = (state_d == S_PULSE_HI);
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge system_clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 20'd0;
            period_q     <= 24'd0;
            rr_b_q       <= 1'b0;
            retry_q      <= 2'd0;
            map_out_q    <= DEFAULT_MAP;
            map_valid_q  <= 1'b0;
            scan_error_q <= 1'b0;
            scan_done_q  <= 1'b0;
            gnt_a_q      <= 1'b0;
            gnt_b_q      <= 1'b0;
            trig_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            period_q     <= period_d;
            rr_b_q       <= rr_b_d;
            retry_q      <= retry_d;
            map_out_q    <= map_out_d;
            map_valid_q  <= map_valid_d;
            scan_error_q <= scan_error_d;
            scan_done_q  <= scan_done_d;
            gnt_a_q      <= gnt_a_d;
            gnt_b_q      <= gnt_b_d;
            trig_q       <= trig_d;
            busy_q       <= busy_d;
        end
    end

    assign gnt_a             = gnt_a_q;
    assign gnt_b             = gnt_b_q;
    assign get_crystal_array = trig_q;
    assign map_out           = map_out_q;
    assign map_valid         = map_valid_q;
    assign scan_busy         = busy_q;
    assign scan_done         = scan_done_q;
    assign scan_error        = scan_error_q;
    assign retry_cnt         = retry_q;

endmodule
